uart_rx: RTL and testbench

Serial receiver of the UART: the stage directly downstream of the `Tx` transmitter. It consumes the serial line that `Tx` drives and the 16x oversampling `tick` from `Baud_Rate_Generator`. It detects the start bit, samples each data bit at mid-bit, and delivers the assembled byte with a one-cycle completion pulse. It reports a framing error when the stop bit is wrong and, when configured in, a parity error.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
//   state_t            : FSM state encoding (IDLE/START/DATA/PARITY/STOP, 3 bits)
//   OVERSAMPLE         : ticks per bit period
//   MID_TICK           : tick index of the mid start-bit sample
//   DEFAULT_DATA_BITS  : default data bits per frame
//   DEFAULT_SB_TICKS   : default ticks spent in the stop bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned MID_TICK          = 7;
  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned DEFAULT_SB_TICKS  = 16;

endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for an asynchronous, idle-high line.
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset; both flops reset to 1
//   d       in  asynchronous input
//   q       out synchronized output
module rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver with 16x oversampling.
//   clock        in  system clock
//   reset_n      in  asynchronous active-low reset
//   tick_in      in  oversampling strobe, 16 per bit period
//   rx_in        in  asynchronous serial line, idle high
//   dato_out     out last received word, held until the next frame completes
//   rx_done_tick out one-cycle pulse when dato_out/error flags update
//   frame_err    out stop bit sampled low on the last frame
//   parity_err   out parity mismatch on the last frame (UART_RX_PARITY_EN only)
// Macro UART_RX_PARITY_EN: expect one even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned SB_TICKS  = DEFAULT_SB_TICKS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] dato_out,
  output logic                 rx_done_tick,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned S_W = (SB_TICKS > OVERSAMPLE) ? $clog2(SB_TICKS) : $clog2(OVERSAMPLE);
  localparam int unsigned N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_s;
  logic                 rx_prev;
  state_t               state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] dato_d;
  logic                 done_d;
  logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 p_q, p_d;
  logic                 perr_d;
`endif

  rx_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dato_d  = dato_out;
    done_d  = 1'b0;
    ferr_d  = frame_err;
`ifdef UART_RX_PARITY_EN
    p_d     = p_q;
    perr_d  = parity_err;
`endif
    case (state_q)
      // Edge detection runs every clock; only the counters wait for tick_in.
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick_in) begin
          if (s_q == S_W'(MID_TICK)) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_in) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DATA_BITS-1:1]};
            if (n_q == N_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_in) begin
          if (s_q == S_W'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            p_d     = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_in) begin
          if (s_q == S_W'(SB_TICKS - 1)) begin
            dato_d  = b_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ p_q;
`endif
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev      <= 1'b1;
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dato_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q          <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_prev      <= rx_s;
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      dato_out     <= dato_d;
      rx_done_tick <= done_d;
      frame_err    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      p_q          <= p_d;
      parity_err   <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a scoreboard of expected words/flags.
module tb_uart_rx;

  localparam int unsigned BITCLK = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic       rx_in;
  logic [7:0] dato_out;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  logic [1:0] tdiv = 2'd0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests  = 0;
  int   fails  = 0;
  int   pulses = 0;
  int   frames = 0;
  logic prev_done = 1'b0;

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tick_in      (tick_in),
    .rx_in        (rx_in),
    .dato_out     (dato_out),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) tdiv <= tdiv + 2'd1;
  assign tick_in = (tdiv == 2'd3);

  task automatic hold(input logic v, input int unsigned clocks);
    rx_in = v;
    repeat (clocks) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
    e.pe = (^d) ^ pbit;
    sb.push_back(e);
    frames++;
    hold(1'b0, BITCLK);
    for (int i = 0; i < 8; i++) hold(d[i], BITCLK);
`ifdef UART_RX_PARITY_EN
    hold(pbit, BITCLK);
`endif
    hold(stop, BITCLK);
  endtask

  // Scoreboard monitor: pops one expectation per completion pulse.
  always @(negedge clock) begin
    if (prev_done) begin
      tests++;
      assert (rx_done_tick === 1'b0) else begin
        fails++;
        $error("FAIL pulse_width observed=%b expected=0", rx_done_tick);
      end
    end
    if (rx_done_tick === 1'b1) begin
      pulses++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pulse observed=%h expected=no_pulse", dato_out);
      end
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        tests++;
        assert (dato_out === cur.d) else begin
          fails++;
          $error("FAIL dato_out observed=%h expected=%h", dato_out, cur.d);
        end
        tests++;
        assert (frame_err === cur.fe) else begin
          fails++;
          $error("FAIL frame_err observed=%b expected=%b", frame_err, cur.fe);
        end
`ifdef UART_RX_PARITY_EN
        tests++;
        assert (parity_err === cur.pe) else begin
          fails++;
          $error("FAIL parity_err observed=%b expected=%b", parity_err, cur.pe);
        end
`endif
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (5) @(negedge clock);
    tests++;
    assert (dato_out === 8'h00) else begin
      fails++;
      $error("FAIL reset_dato observed=%h expected=00", dato_out);
    end
    tests++;
    assert (rx_done_tick === 1'b0) else begin
      fails++;
      $error("FAIL reset_done observed=%b expected=0", rx_done_tick);
    end
    tests++;
    assert (frame_err === 1'b0) else begin
      fails++;
      $error("FAIL reset_ferr observed=%b expected=0", frame_err);
    end
    reset_n = 1'b1;
    hold(1'b1, 100);

    // Basic frame
    send_frame(8'h25, 1'b1, 1'b1);
    hold(1'b1, 100);

    // Short low glitch (4 ticks) must be rejected, then a good frame
    hold(1'b0, 16);
    hold(1'b1, 200);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, 100);

    // Framing error, then recovery
    send_frame(8'hC3, 1'b0, 1'b0);
    hold(1'b1, 100);
    send_frame(8'h01, 1'b1, 1'b1);
    hold(1'b1, 100);

    // Back-to-back frames without idle gap
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 100);

    // Reset during data bit 4 of 0xFF: partial frame discarded
    hold(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) hold(1'b1, BITCLK);
    hold(1'b1, 20);
    reset_n = 1'b0;
    #1;
    tests++;
    assert (dato_out === 8'h00) else begin
      fails++;
      $error("FAIL midreset_dato observed=%h expected=00", dato_out);
    end
    tests++;
    assert (rx_done_tick === 1'b0) else begin
      fails++;
      $error("FAIL midreset_done observed=%b expected=0", rx_done_tick);
    end
    tests++;
    assert (frame_err === 1'b0) else begin
      fails++;
      $error("FAIL midreset_ferr observed=%b expected=0", frame_err);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    hold(1'b1, 200);
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, 100);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h25, 1'b1, 1'b1);
    hold(1'b1, 100);
    send_frame(8'h25, 1'b1, 1'b0);
    hold(1'b1, 100);
`endif

    hold(1'b1, 200);
    tests++;
    assert (pulses === frames) else begin
      fails++;
      $error("FAIL pulse_count observed=%0d expected=%0d", pulses, frames);
    end
    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL pending_frames observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
